// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its interval timer:
// timer FSM state encoding and the default interval settings both sides agree on.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COUNT      = 2'd1,
        SHORT_DONE = 2'd2,
        LONG_DONE  = 2'd3
    } tmr_state_t;

    localparam int TMR_W         = 16;
    localparam int TMR_PRESCALE  = 1000;
    localparam int TMR_SHORT_DEF = 3;
    localparam int TMR_LONG_DEF  = 10;

endpackage

// File: rtl/traffic_interval_timer_if.sv
// Timer-side link of the traffic-light controller: restart/config requests in,
// elapsed flags and running status out.
interface traffic_interval_timer_if #(
    parameter int W = 16
);
    logic         st;
    logic         cfg_we;
    logic [W-1:0] cfg_short;
    logic [W-1:0] cfg_long;
    logic         ts;
    logic         tl;
    logic         running;

    modport master (
        output st, cfg_we, cfg_short, cfg_long,
        input  ts, tl, running
    );

    modport slave (
        input  st, cfg_we, cfg_short, cfg_long,
        output ts, tl, running
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle tick pulses every PRESCALE cycles; clr restarts the
// division so the first tick after a restart lands exactly PRESCALE cycles later.
module tick_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        tick  = (pre_q == LAST);
        pre_d = pre_q + PW'(1);
        if (clr || tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/traffic_interval_timer.sv
// Interval timer for the traffic-light controller: restarts on st, then raises sticky
// ts after the short interval and tl after the long interval, counted in prescaled ticks.
module traffic_interval_timer
    import traffic_pkg::*;
#(
    parameter int W         = TMR_W,
    parameter int PRESCALE  = TMR_PRESCALE,
    parameter int SHORT_DEF = TMR_SHORT_DEF,
    parameter int LONG_DEF  = TMR_LONG_DEF
) (
    input logic                     clk,
    input logic                     rst,
    traffic_interval_timer_if.slave bus
);
    localparam logic [W-1:0] SHORT_RST = W'(SHORT_DEF);
    localparam logic [W-1:0] LONG_RST  = W'(LONG_DEF);

    function automatic logic [W-1:0] clamp_short(input logic [W-1:0] v);
        return (v == '0) ? W'(1) : v;
    endfunction

    function automatic logic [W-1:0] clamp_long(input logic [W-1:0] l, input logic [W-1:0] s);
        return (l < s) ? s : l;
    endfunction

    tmr_state_t   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] sh_s_q, sh_s_d, lg_s_q, lg_s_d;
    logic [W-1:0] sh_a_q, sh_a_d, lg_a_q, lg_a_d;
    logic         ts_q, ts_d, tl_q, tl_d;
    logic         tick;
    logic [W-1:0] src_short, src_long, ld_short, ld_long, cnt_inc;
    logic         ts_due, tl_due;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.st),
        .tick (tick)
    );

    always_comb begin
        // A config write coinciding with st is forwarded straight into the active intervals.
        src_short = bus.cfg_we ? bus.cfg_short : sh_s_q;
        src_long  = bus.cfg_we ? bus.cfg_long  : lg_s_q;
        ld_short  = clamp_short(src_short);
        ld_long   = clamp_long(src_long, ld_short);
        cnt_inc   = cnt_q + W'(1);
        ts_due    = (cnt_inc >= sh_a_q);
        tl_due    = (cnt_inc >= lg_a_q);

        state_d = state_q;
        cnt_d   = cnt_q;
        sh_s_d  = sh_s_q;
        lg_s_d  = lg_s_q;
        sh_a_d  = sh_a_q;
        lg_a_d  = lg_a_q;
        ts_d    = ts_q;
        tl_d    = tl_q;

        if (bus.cfg_we) begin
            sh_s_d = bus.cfg_short;
            lg_s_d = bus.cfg_long;
        end

        if (bus.st) begin
            state_d = COUNT;
            cnt_d   = '0;
            ts_d    = 1'b0;
            tl_d    = 1'b0;
            sh_a_d  = ld_short;
            lg_a_d  = ld_long;
        end else begin
            unique case (state_q)
                COUNT: begin
                    if (tick) begin
                        cnt_d = cnt_inc;
                        ts_d  = ts_due;
                        tl_d  = tl_due;
                        if (tl_due) begin
                            state_d = LONG_DONE;
                        end else if (ts_due) begin
                            state_d = SHORT_DONE;
                        end
                    end
                end
                SHORT_DONE: begin
                    if (tick) begin
                        cnt_d = cnt_inc;
                        tl_d  = tl_due;
                        if (tl_due) begin
                            state_d = LONG_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_s_q  <= SHORT_RST;
            lg_s_q  <= LONG_RST;
            sh_a_q  <= SHORT_RST;
            lg_a_q  <= LONG_RST;
            ts_q    <= 1'b0;
            tl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_s_q  <= sh_s_d;
            lg_s_q  <= lg_s_d;
            sh_a_q  <= sh_a_d;
            lg_a_q  <= lg_a_d;
            ts_q    <= ts_d;
            tl_q    <= tl_d;
        end
    end

    assign bus.ts      = ts_q;
    assign bus.tl      = tl_q;
    assign bus.running = (state_q == COUNT) || (state_q == SHORT_DONE);
endmodule

// File: tb/tb_traffic_interval_timer.sv
// Drives identical stimulus into a PRESCALE=1 and a PRESCALE=4 timer and checks both
// against a restart-timeline model through an expected-value queue.
module tb_traffic_interval_timer;
    localparam int W = 16;

    typedef struct packed {
        logic [2:0] p1;
        logic [2:0] p4;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_interval_timer_if #(.W(W)) bus1 ();
    traffic_interval_timer_if #(.W(W)) bus4 ();

    traffic_interval_timer #(.W(W), .PRESCALE(1), .SHORT_DEF(3), .LONG_DEF(10)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    traffic_interval_timer #(.W(W), .PRESCALE(4), .SHORT_DEF(3), .LONG_DEF(10)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    string       phase = "init";

    int unsigned edge_n  = 0;
    bit          started = 1'b0;
    int unsigned e_edge  = 0;
    int unsigned sh_s    = 3;
    int unsigned lg_s    = 10;
    int unsigned sh_a    = 3;
    int unsigned lg_a    = 10;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] expect_for(input int unsigned p);
        int unsigned d;
        logic        ts_e, tl_e;
        d    = edge_n - e_edge;
        ts_e = started && (d >= sh_a * p);
        tl_e = started && (d >= lg_a * p);
        return {ts_e, tl_e, started && !tl_e};
    endfunction

    task automatic step(input logic r, input logic s, input logic we,
                        input int unsigned cs, input int unsigned cl);
        exp_t e;
        rst            = r;
        bus1.st        = s;
        bus4.st        = s;
        bus1.cfg_we    = we;
        bus4.cfg_we    = we;
        bus1.cfg_short = W'(cs);
        bus4.cfg_short = W'(cs);
        bus1.cfg_long  = W'(cl);
        bus4.cfg_long  = W'(cl);
        @(posedge clk);
        edge_n++;
        if (r) begin
            started = 1'b0;
            sh_s    = 3;
            lg_s    = 10;
        end else begin
            if (we) begin
                sh_s = cs;
                lg_s = cl;
            end
            if (s) begin
                started = 1'b1;
                e_edge  = edge_n;
                sh_a    = (sh_s == 0) ? 1 : sh_s;
                lg_a    = (lg_s < sh_a) ? sh_a : lg_s;
            end
        end
        e.p1 = expect_for(1);
        e.p4 = expect_for(4);
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            check_val({phase, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val({phase, "/p1"}, {29'd0, bus1.ts, bus1.tl, bus1.running}, {29'd0, e.p1});
            check_val({phase, "/p4"}, {29'd0, bus4.ts, bus4.tl, bus4.running}, {29'd0, e.p4});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        phase = "reset";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
        phase = "idle";
        idle(50);

        phase = "defaults";
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(45);

        phase = "cfg2_5";
        step(1'b0, 1'b0, 1'b1, 2, 5);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(25);

        phase = "restart";
        step(1'b0, 1'b0, 1'b1, 3, 10);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(20);

        phase = "st_held";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(14);

        phase = "fwd6_2";
        step(1'b0, 1'b1, 1'b1, 6, 2);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1, 1);
        idle(30);

        phase = "short0_rst";
        step(1'b0, 1'b0, 1'b1, 0, 10);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        idle(5);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle(45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
